// File: rtl/rtos_eventflag_unit_if.sv
// WISHBONE slave bundle for the event-flag unit; the host drives the master side.
interface rtos_eventflag_unit_if #(
    parameter int WB_ADR_WIDTH = 8,
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
    logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
    logic                    s_wb_we_i;
    logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
    logic                    s_wb_stb_i;
    logic                    s_wb_ack_o;

    modport master (
        output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        input  s_wb_dat_o, s_wb_ack_o
    );

    modport slave (
        input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        output s_wb_dat_o, s_wb_ack_o
    );
endinterface

// File: rtl/rtos_eventflag_unit.sv
// Event-flag object for the hardware RTOS: flag register plus one wait slot per
// task releasing in AND, OR or AND-with-clear mode, on a one-wait-state WISHBONE slave.
module rtos_eventflag_unit #(
    parameter int                    TASKS        = 8,
    parameter int                    ID_WIDTH     = 4,
    parameter int                    FLAG_WIDTH   = 32,
    parameter int                    WB_ADR_WIDTH = 8,
    parameter int                    WB_DAT_WIDTH = 32,
    parameter int                    WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter logic [FLAG_WIDTH-1:0] INIT_FLAG    = '0,
    parameter logic [31:0]           CORE_ID      = 32'h527a_0110
) (
    input  logic                  wb_rst_i,
    input  logic                  wb_clk_i,
    rtos_eventflag_unit_if.slave  s_wb,
    output logic [FLAG_WIDTH-1:0] flag_o,
    output logic [TASKS-1:0]      waiting_o,
    output logic [TASKS-1:0]      wakeup_o
);

    localparam int TIDX_W = (TASKS > 1) ? $clog2(TASKS) : 1;

    localparam logic [3:0] OP_REF         = 4'd0;
    localparam logic [3:0] OP_SET_FLG     = 4'd1;
    localparam logic [3:0] OP_CLR_FLG     = 4'd2;
    localparam logic [3:0] OP_WAI_AND     = 4'd3;
    localparam logic [3:0] OP_WAI_OR      = 4'd4;
    localparam logic [3:0] OP_WAI_AND_CLR = 4'd5;
    localparam logic [3:0] OP_CAN_WAI     = 4'd6;
    localparam logic [3:0] OP_REF_RELPTN  = 4'd7;

    logic                    ack_p1;
    logic [WB_DAT_WIDTH-1:0] dat_p1;
    logic [FLAG_WIDTH-1:0]   flag_p1;
    logic [TASKS-1:0]        wakeup_p1;
    logic                    err_p1;
    logic [TASKS-1:0]        slot_vld;
    logic [TASKS-1:0]        slot_or;
    logic [TASKS-1:0]        slot_clr;
    logic [FLAG_WIDTH-1:0]   slot_ptn [TASKS];
    logic [FLAG_WIDTH-1:0]   relptn   [TASKS];

    function automatic logic slot_hit(input logic [FLAG_WIDTH-1:0] f,
                                      input logic [FLAG_WIDTH-1:0] p,
                                      input logic                  or_mode);
        return or_mode ? (|(f & p)) : ((f & p) == p);
    endfunction

    logic [3:0]              op;
    logic [ID_WIDTH-1:0]     id;
    logic [TIDX_W-1:0]       tid;
    logic [FLAG_WIDTH-1:0]   ptn_in;
    logic                    commit, wr, rd, id_ok, perr, wai_wr, can_wr;
    logic [WB_DAT_WIDTH-1:0] be;
    logic [FLAG_WIDTH-1:0]   set_dat, clr_dat, clr_mask, flag_nxt;
    logic [TASKS-1:0]        rel;
    logic [WB_DAT_WIDTH-1:0] rd_data;

    assign op     = s_wb.s_wb_adr_i[WB_ADR_WIDTH-1 -: 4];
    assign id     = s_wb.s_wb_adr_i[ID_WIDTH-1:0];
    assign tid    = id[TIDX_W-1:0];
    assign ptn_in = s_wb.s_wb_dat_i[FLAG_WIDTH-1:0];
    assign commit = s_wb.s_wb_stb_i & ~ack_p1;
    assign wr     = commit & s_wb.s_wb_we_i;
    assign rd     = commit & ~s_wb.s_wb_we_i;
    assign id_ok  = (32'(id) < 32'(TASKS));

    // Slot commands and the release-pattern read share the parameter check.
    assign perr   = ((wr && op >= OP_WAI_AND && op <= OP_CAN_WAI) || (rd && op == OP_REF_RELPTN))
                    && ((ptn_in == '0) || !id_ok);
    assign wai_wr = wr && !perr && (op == OP_WAI_AND || op == OP_WAI_OR || op == OP_WAI_AND_CLR);
    assign can_wr = wr && !perr && (op == OP_CAN_WAI);

    always_comb begin
        be = '0;
        for (int b = 0; b < WB_SEL_WIDTH; b++) be[b*8 +: 8] = {8{s_wb.s_wb_sel_i[b]}};
    end

    // A slot being rewritten by the host this edge does not release.
    always_comb begin
        rel      = '0;
        clr_mask = '0;
        for (int i = 0; i < TASKS; i++) begin
            if (slot_vld[i] && slot_hit(flag_p1, slot_ptn[i], slot_or[i])
                && !((wai_wr || can_wr) && (tid == TIDX_W'(i)))) begin
                rel[i] = 1'b1;
                if (slot_clr[i]) clr_mask = clr_mask | slot_ptn[i];
            end
        end
    end

    assign set_dat  = (wr && op == OP_SET_FLG) ? (ptn_in & be[FLAG_WIDTH-1:0]) : '0;
    assign clr_dat  = (wr && op == OP_CLR_FLG) ? (ptn_in | ~be[FLAG_WIDTH-1:0]) : '1;
    assign flag_nxt = ((flag_p1 & ~clr_mask) & clr_dat) | set_dat;

    always_comb begin
        rd_data = '0;
        if (rd) begin
            if (op == OP_REF) begin
                if (id == ID_WIDTH'(0))      rd_data = WB_DAT_WIDTH'(flag_p1);
                else if (id == ID_WIDTH'(1)) rd_data = WB_DAT_WIDTH'(slot_vld);
                else if (id == ID_WIDTH'(2)) rd_data = WB_DAT_WIDTH'(CORE_ID);
                else if (id == ID_WIDTH'(3)) rd_data = WB_DAT_WIDTH'(err_p1);
            end else if (op == OP_REF_RELPTN && !perr) begin
                rd_data = WB_DAT_WIDTH'(relptn[tid]);
            end
        end
    end

    // Stage p1: bus response, flag register, slot state and release outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_p1    <= 1'b0;
            dat_p1    <= '0;
            flag_p1   <= INIT_FLAG;
            wakeup_p1 <= '0;
            err_p1    <= 1'b0;
            slot_vld  <= '0;
            for (int i = 0; i < TASKS; i++) relptn[i] <= '0;
        end else begin
            ack_p1    <= s_wb.s_wb_stb_i & ~ack_p1;
            if (commit) dat_p1 <= rd_data;
            flag_p1   <= flag_nxt;
            wakeup_p1 <= rel;
            for (int i = 0; i < TASKS; i++) begin
                if (rel[i]) begin
                    slot_vld[i] <= 1'b0;
                    relptn[i]   <= flag_p1;
                end
            end
            if (wai_wr)      slot_vld[tid] <= 1'b1;
            else if (can_wr) slot_vld[tid] <= 1'b0;
            if (perr)        err_p1 <= 1'b1;
            else if (wr && op == OP_REF && id == ID_WIDTH'(3)) err_p1 <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wai_wr) begin
            slot_ptn[tid] <= ptn_in;
            slot_or[tid]  <= (op == OP_WAI_OR);
            slot_clr[tid] <= (op == OP_WAI_AND_CLR);
        end
    end

    assign s_wb.s_wb_ack_o = ack_p1;
    assign s_wb.s_wb_dat_o = dat_p1;
    assign flag_o          = flag_p1;
    assign waiting_o       = slot_vld;
    assign wakeup_o        = wakeup_p1;

endmodule

// File: tb/tb_rtos_eventflag_unit.sv
// Bench for rtos_eventflag_unit: directed scenarios plus random bus traffic
// against a per-cycle behavioural model of the event-flag object.
module tb_rtos_eventflag_unit;
    localparam int          TASKS   = 8;
    localparam logic [31:0] CORE_ID = 32'h527a_0110;

    localparam logic [3:0] OP_REF = 4'd0, OP_SET = 4'd1, OP_CLR = 4'd2, OP_WAND = 4'd3,
                           OP_WOR = 4'd4, OP_WCLR = 4'd5, OP_CAN = 4'd6, OP_RELPTN = 4'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtos_eventflag_unit_if bus ();
    logic [31:0] flag_o;
    logic [7:0]  waiting_o, wakeup_o;

    rtos_eventflag_unit dut (
        .wb_rst_i  (rst_n),
        .wb_clk_i  (clk),
        .s_wb      (bus.slave),
        .flag_o    (flag_o),
        .waiting_o (waiting_o),
        .wakeup_o  (wakeup_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the event-flag object's visible state.
    logic [31:0] m_flag, m_dat;
    bit   [7:0]  m_valid, m_wake;
    bit          m_err, m_ack;
    logic [31:0] m_ptn [TASKS];
    int          m_mode[TASKS];  // 0 AND, 1 OR, 2 AND-with-clear
    logic [31:0] m_rel [TASKS];

    function automatic bit satisfied(input logic [31:0] f, input logic [31:0] p, input int mode);
        if (mode == 1) return (f & p) != 32'h0;
        return (f & p) == p;
    endfunction

    task automatic model_reset();
        m_flag = 32'h0; m_dat = 32'h0; m_valid = '0; m_wake = '0; m_err = 0; m_ack = 0;
        for (int i = 0; i < TASKS; i++) begin
            m_rel[i] = 32'h0; m_ptn[i] = 32'h0; m_mode[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [31:0] f, dat, mask, be, setd, clrd, rdat;
        bit [7:0] rel;
        bit cm, we, perr, slot_cmd;
        int op, id;
        f    = m_flag;
        dat  = bus.s_wb_dat_i;
        we   = bus.s_wb_we_i;
        op   = int'(bus.s_wb_adr_i[7:4]);
        id   = int'(bus.s_wb_adr_i[3:0]);
        cm   = bus.s_wb_stb_i && !m_ack;
        perr = cm && ((we && op >= 3 && op <= 6) || (!we && op == 7)) && (dat == 32'h0 || id >= TASKS);
        slot_cmd = cm && we && !perr && op >= 3 && op <= 6;
        rel  = '0;
        mask = 32'h0;
        for (int i = 0; i < TASKS; i++) begin
            if (m_valid[i] && satisfied(f, m_ptn[i], m_mode[i]) && !(slot_cmd && id == i)) begin
                rel[i] = 1'b1;
                if (m_mode[i] == 2) mask = mask | m_ptn[i];
            end
        end
        for (int b = 0; b < 4; b++) be[8*b +: 8] = {8{bus.s_wb_sel_i[b]}};
        setd = (cm && we && op == 1) ? (dat & be) : 32'h0;
        clrd = (cm && we && op == 2) ? (dat | ~be) : 32'hFFFF_FFFF;
        rdat = 32'h0;
        if (cm && !we) begin
            if (op == 0) begin
                case (id)
                    0: rdat = f;
                    1: rdat = 32'(m_valid);
                    2: rdat = CORE_ID;
                    3: rdat = 32'(m_err);
                    default: rdat = 32'h0;
                endcase
            end else if (op == 7 && !perr) begin
                rdat = m_rel[id];
            end
        end
        for (int i = 0; i < TASKS; i++) begin
            if (rel[i]) begin
                m_valid[i] = 1'b0;
                m_rel[i]   = f;
            end
        end
        if (slot_cmd) begin
            if (op == 6) m_valid[id] = 1'b0;
            else begin
                m_valid[id] = 1'b1;
                m_ptn[id]   = dat;
                m_mode[id]  = op - 3;
            end
        end
        if (perr) m_err = 1'b1;
        else if (cm && we && op == 0 && id == 3) m_err = 1'b0;
        m_flag = ((f & ~mask) & clrd) | setd;
        m_wake = rel;
        m_ack  = cm;
        if (cm) m_dat = rdat;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ack",     32'(bus.s_wb_ack_o), 32'(m_ack));
            check("dat_o",   bus.s_wb_dat_o,      m_dat);
            check("flag_o",  flag_o,              m_flag);
            check("waiting", 32'(waiting_o),      32'(m_valid));
            check("wakeup",  32'(wakeup_o),       32'(m_wake));
        end
    end

    task automatic access(input bit we, input logic [3:0] op, input logic [3:0] id,
                          input logic [31:0] dat, input logic [3:0] sel, output logic [31:0] rdv);
        @(negedge clk);
        bus.s_wb_adr_i = {op, id};
        bus.s_wb_dat_i = dat;
        bus.s_wb_we_i  = we;
        bus.s_wb_sel_i = sel;
        bus.s_wb_stb_i = 1'b1;
        @(negedge clk);
        rdv = bus.s_wb_dat_o;
        bus.s_wb_stb_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] op, input logic [3:0] id, input logic [31:0] dat);
        logic [31:0] unused;
        access(1'b1, op, id, dat, 4'hF, unused);
    endtask

    task automatic rd_check(input string name, input logic [3:0] op, input logic [3:0] id,
                            input logic [31:0] exp);
        logic [31:0] v;
        access(1'b0, op, id, 32'h1, 4'hF, v);
        check(name, v, exp);
    endtask

    task automatic expect_wake(input string name, input logic [7:0] exp);
        @(negedge clk);
        check(name, 32'(wakeup_o), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [3:0]  op, id, sel;
        logic [31:0] d, rdv;
        bit          we;
        int          k;

        bus.s_wb_adr_i = '0; bus.s_wb_dat_i = '0; bus.s_wb_we_i = 1'b0;
        bus.s_wb_sel_i = '0; bus.s_wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        rd_check("ref_init_flag", OP_REF, 4'd0, 32'h0);
        rd_check("ref_core_id",   OP_REF, 4'd2, CORE_ID);

        // Asynchronous reset in the middle of an access with stb held.
        wr(OP_WAND, 4'd5, 32'h80);
        check("wait_slot5", 32'(waiting_o), 32'h20);
        @(negedge clk);
        bus.s_wb_adr_i = {OP_SET, 4'd0}; bus.s_wb_dat_i = 32'h80;
        bus.s_wb_we_i = 1'b1; bus.s_wb_sel_i = 4'hF; bus.s_wb_stb_i = 1'b1;
        @(posedge clk);
        #1 check("ack_before_rst", 32'(bus.s_wb_ack_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack",     32'(bus.s_wb_ack_o), 32'h0);
        check("rst_wakeup",  32'(wakeup_o),       32'h0);
        check("rst_waiting", 32'(waiting_o),      32'h0);
        check("rst_flag",    flag_o,              32'h0);
        @(negedge clk);
        bus.s_wb_stb_i = 1'b0;
        rst_n = 1'b1;
        rd_check("ref_after_rst", OP_REF, 4'd0, 32'h0);

        // AND wait.
        wr(OP_WAND, 4'd0, 32'h5);
        wr(OP_SET, 4'd0, 32'h1);
        expect_wake("and_partial", 8'h00);
        wr(OP_SET, 4'd0, 32'h4);
        expect_wake("and_release", 8'h01);
        rd_check("and_relptn", OP_RELPTN, 4'd0, 32'h5);
        check("and_waiting", 32'(waiting_o), 32'h0);

        // OR wait released together with an AND wait.
        wr(OP_CLR, 4'd0, 32'h0);
        wr(OP_WOR,  4'd1, 32'h6);
        wr(OP_WAND, 4'd2, 32'h2);
        wr(OP_SET,  4'd0, 32'h2);
        expect_wake("or_and_same_edge", 8'h06);
        check("or_and_waiting", 32'(waiting_o), 32'h0);

        // Clear-on-release.
        wr(OP_CLR, 4'd0, 32'h0);
        wr(OP_WCLR, 4'd3, 32'h3);
        wr(OP_SET, 4'd0, 32'h7);
        expect_wake("clr_release", 8'h08);
        rd_check("clr_flag", OP_REF, 4'd0, 32'h4);
        rd_check("clr_relptn", OP_RELPTN, 4'd3, 32'h7);

        // Byte selects.
        wr(OP_SET, 4'd0, 32'hFFFF_FFFF);
        access(1'b1, OP_CLR, 4'd0, 32'h0, 4'b0010, rdv);
        rd_check("clr_byte1", OP_REF, 4'd0, 32'hFFFF_00FF);
        wr(OP_CLR, 4'd0, 32'h0);
        access(1'b1, OP_SET, 4'd0, 32'hAA55_55FF, 4'b1000, rdv);
        rd_check("set_byte3", OP_REF, 4'd0, 32'hAA00_0000);

        // Parameter errors and cancel.
        wr(OP_WAND, 4'd3, 32'h0);
        rd_check("err_zero_ptn", OP_REF, 4'd3, 32'h1);
        check("err_slot3_idle", 32'(waiting_o), 32'h0);
        wr(OP_WAND, 4'd9, 32'h1);
        rd_check("err_bad_id", OP_REF, 4'd3, 32'h1);
        wr(OP_REF, 4'd3, 32'h0);
        rd_check("err_cleared", OP_REF, 4'd3, 32'h0);
        wr(OP_CLR, 4'd0, 32'h0);
        wr(OP_WOR, 4'd4, 32'h1);
        check("cancel_armed", 32'(waiting_o), 32'h10);
        wr(OP_CAN, 4'd4, 32'h1);
        wr(OP_SET, 4'd0, 32'h1);
        expect_wake("cancel_no_wake", 8'h00);
        check("cancel_waiting", 32'(waiting_o), 32'h0);
        wr(OP_WOR, 4'd6, 32'h100);
        rd_check("ref_bitmap", OP_REF, 4'd1, 32'h40);
        wr(OP_CAN, 4'd6, 32'h1);

        // Random traffic checked cycle by cycle against the model.
        for (int it = 0; it < 400; it++) begin
            k = int'($urandom_range(0, 9));
            case (k)
                0:       op = OP_REF;
                1, 2:    op = OP_SET;
                3:       op = OP_CLR;
                4:       op = OP_WAND;
                5:       op = OP_WOR;
                6:       op = OP_WCLR;
                7:       op = OP_CAN;
                8:       op = OP_RELPTN;
                default: op = 4'($urandom_range(8, 15));
            endcase
            id = (op == OP_REF) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0:       d = 32'h1 << $urandom_range(0, 7);
                1:       d = $urandom & 32'hFF;
                2:       d = $urandom;
                default: d = 32'h0;
            endcase
            if (op == OP_CLR && $urandom_range(0, 1) == 1) d = ~d;
            if ((op == OP_CAN || op == OP_RELPTN) && d == 32'h0) d = 32'h1;
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            we  = !(op == OP_RELPTN || (op == OP_REF && $urandom_range(0, 3) != 0));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                bus.s_wb_adr_i = {op, id}; bus.s_wb_dat_i = d;
                bus.s_wb_we_i = we; bus.s_wb_sel_i = sel; bus.s_wb_stb_i = 1'b1;
                repeat (4) @(negedge clk);
                bus.s_wb_stb_i = 1'b0;
            end else begin
                access(we, op, id, d, sel, rdv);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
